// File: rtl/spi_master_ctrl.sv
// SPI frame master: select, 11-bit command shift, optional 8-bit read, idle gap; SPI_MASTER_SEQ_CHK_EN adds read-order checking.
// Latency: 1+11+IDLE_GAP cycles per write/read-addr frame, 1+11+RD_LATENCY+8+IDLE_GAP per read-data frame.
// Backpressure: start is only honoured while idle; requests during a frame are dropped, never queued.
module spi_master_ctrl #(
    parameter int RD_LATENCY = 2,
    parameter int IDLE_GAP   = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] cmd,
    input  logic [7:0] wdata,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       err,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    typedef enum logic [2:0] {IDLE, SELECT, SHIFT, WAIT_RD, RECV, GAP} state_t;

    localparam logic [3:0] WAIT_LD = 4'(RD_LATENCY - 1);
    localparam logic [3:0] GAP_LD  = 4'(IDLE_GAP - 1);

    state_t      state, next_state;
    logic [3:0]  cnt, next_cnt;
    logic [10:0] frame;
    logic [6:0]  shreg;

    logic        ss_n_d, mosi_d, busy_d, done_d, rd_valid_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // cnt holds the cycles remaining in the current state; reloaded on every entry
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = SELECT;
                    next_cnt   = 4'd0;
                end
            end
            SELECT: begin
                next_state = SHIFT;
                next_cnt   = 4'd10;
            end
            SHIFT: begin
                if (cnt != 4'd0) begin
                    next_cnt = cnt - 4'd1;
                end else if (frame[9:8] == 2'b11) begin
                    if (RD_LATENCY == 0) begin
                        next_state = RECV;
                        next_cnt   = 4'd7;
                    end else begin
                        next_state = WAIT_RD;
                        next_cnt   = WAIT_LD;
                    end
                end else begin
                    next_state = GAP;
                    next_cnt   = GAP_LD;
                end
            end
            WAIT_RD: begin
                if (cnt != 4'd0) begin
                    next_cnt = cnt - 4'd1;
                end else begin
                    next_state = RECV;
                    next_cnt   = 4'd7;
                end
            end
            RECV: begin
                if (cnt != 4'd0) begin
                    next_cnt = cnt - 4'd1;
                end else begin
                    next_state = GAP;
                    next_cnt   = GAP_LD;
                end
            end
            GAP: begin
                if (cnt != 4'd0) begin
                    next_cnt = cnt - 4'd1;
                end else begin
                    next_state = IDLE;
                    next_cnt   = 4'd0;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = 4'd0;
            end
        endcase
    end

    // Outputs are decoded from the upcoming state so the registered pins line up with it
    always_comb begin
        ss_n_d     = !(next_state == SELECT || next_state == SHIFT ||
                       next_state == WAIT_RD || next_state == RECV);
        mosi_d     = (next_state == SHIFT) ? frame[next_cnt] : 1'b0;
        busy_d     = (next_state != IDLE);
        done_d     = (next_state == GAP) && (next_cnt == 4'd0);
        rd_valid_d = (state == RECV) && (cnt == 4'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            SS_n     <= 1'b1;
            MOSI     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= 8'h00;
            frame    <= 11'd0;
            shreg    <= 7'd0;
        end else begin
            SS_n     <= ss_n_d;
            MOSI     <= mosi_d;
            busy     <= busy_d;
            done     <= done_d;
            rd_valid <= rd_valid_d;
            if (state == IDLE && start)
                frame <= {cmd[1], cmd, wdata};
            if (state == RECV)
                shreg <= {shreg[5:0], MISO};
            if (rd_valid_d)
                rd_data <= {shreg, MISO};
        end
    end

`ifdef SPI_MASTER_SEQ_CHK_EN
    logic rd_pend;

    // A read-data frame consumes the pending read-addr; one without it flags err but still runs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend <= 1'b0;
            err     <= 1'b0;
        end else if (state == IDLE && start && cmd == 2'b11) begin
            rd_pend <= 1'b0;
            if (!rd_pend)
                err <= 1'b1;
        end else if (state == GAP && cnt == 4'd0 && frame[9:8] == 2'b10) begin
            rd_pend <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule
